// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-side arbiter; the state enum is reused by
// any later read-side scheduler.
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: rotate req so the slot after 'last' sits at bit 0, then
// take the lowest set bit and map it back to an absolute index.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);
  logic [N-1:0] rot;
  logic         found;
  int           off, sum;

  always_comb begin
    rot   = N'({req, req} >> (int'(last) + 1));
    found = 1'b0;
    off   = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = j;
      end
    end
    sum = int'(last) + 1 + off;
    if (sum >= N) sum = sum - N;
    idx  = found ? IW'(sum) : '0;
    pick = '0;
    for (int i = 0; i < N; i++) pick[i] = found && (IW'(i) == idx);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among N_REQ producers: round-robin grant with a
// burst lock held until req_last or MAX_BURST accepted beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IW        = $clog2(N_REQ),
  localparam int CW        = $clog2(MAX_BURST) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       fifo_wdata,
  output logic                   fifo_wen,
  input  logic                   fifo_full,
  output logic [IW-1:0]          owner,
  output logic                   busy
);
  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_owner_q, last_owner_d, pick_idx;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [N_REQ-1:0] pick_oh;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req),
    .last (last_owner_q),
    .pick (pick_oh),
    .idx  (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    grant    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_last = req_last[i];
      end
      // Gated by rst so an abandoned burst cannot slip a beat in the reset cycle
      grant[i] = (state_q == ARB_BURST) && !rst && !fifo_full &&
                 (owner_q == IW'(i)) && req[i];
    end
    fifo_wen   = |grant;
    fifo_wdata = fifo_wen ? sel_data : '0;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (|pick_oh) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (fifo_wen) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (sel_last || beat_cnt_q == CW'(MAX_BURST - 1)) begin
            last_owner_d = owner_q;
            state_d      = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(N_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == ARB_BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter with a behavioural 16-deep FIFO behind it and a
// per-requester scoreboard checked on the FIFO read side.
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, MB = 4, DEPTH = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, req_last = '0, grant;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] fifo_wdata;
  logic fifo_wen, fifo_full = 1'b0, busy;
  logic [1:0] owner;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .grant(grant), .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen),
    .fifo_full(fifo_full), .owner(owner), .busy(busy)
  );

  typedef struct { logic [7:0] data; logic last; int gap; } beat_t;
  beat_t      src[N][$];
  logic [7:0] exp_q[N][$];
  logic [7:0] ord_q[$];
  logic [7:0] fifo_q[$];
  int         grant_log[$];
  logic [3:0] gv_log[$];
  int         wait_cnt[N];
  int         checks = 0, errors = 0, burst_len = 0;
  logic       rd_en = 1'b1, prev_busy = 1'b0;
  logic [1:0] prev_owner = '0;
  logic [5:0] seq[N];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; req_last[i] = 1'b0; req_data[i*W +: W] = '0;
      if (src[i].size() > 0) begin
        req[i]              = (wait_cnt[i] == 0);
        req_last[i]         = src[i][0].last;
        req_data[i*W +: W]  = src[i][0].data;
      end
    end
  endtask

  task automatic load(int i, logic [7:0] d, logic l, int gap, bit ord);
    beat_t b;
    b.data = d; b.last = l; b.gap = gap;
    if (src[i].size() == 0) wait_cnt[i] = gap;
    src[i].push_back(b);
    if (ord) ord_q.push_back(d); else exp_q[i].push_back(d);
    drive();
  endtask

  function automatic bit any_src();
    for (int i = 0; i < N; i++) if (src[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check invariants mid-cycle, then update FIFO model and sources.
  task automatic cycle();
    logic [3:0] g; logic wen, rd, pb; logic [7:0] wd, ew, d, e; logic [1:0] po;
    #1;
    g = grant; wen = fifo_wen; wd = fifo_wdata;
    checks++; if (!$onehot0(grant)) begin errors++; $display("FAIL onehot grant=%b", grant); end
    checks++; if (fifo_wen && fifo_full) begin errors++; $display("FAIL wen_while_full wen=%b full=%b", fifo_wen, fifo_full); end
    checks++; if ((grant & ~req) != 0) begin errors++; $display("FAIL grant_without_req grant=%b req=%b", grant, req); end
    checks++; if (fifo_wen !== (|grant)) begin errors++; $display("FAIL wen_vs_grant wen=%b grant=%b", fifo_wen, grant); end
    ew = '0;
    for (int i = 0; i < N; i++) if (grant[i]) ew = req_data[i*W +: W];
    checks++; if (fifo_wdata !== ew) begin errors++; $display("FAIL wdata got=%h exp=%h", fifo_wdata, ew); end
    if (busy && prev_busy) begin
      checks++; if (owner !== prev_owner) begin errors++; $display("FAIL owner_changed got=%0d exp=%0d", owner, prev_owner); end
    end
    if (!busy) burst_len = 0;
    if (g != 0) begin
      burst_len++;
      checks++; if (burst_len > MB) begin errors++; $display("FAIL burst_len got=%0d max=%0d", burst_len, MB); end
    end
    rd = rd_en && (fifo_q.size() > 0);
    pb = busy; po = owner;
    @(posedge clk); #1;
    prev_busy = pb; prev_owner = po;
    gv_log.push_back(g);
    if (rd) begin
      d = fifo_q.pop_front();
      if (ord_q.size() > 0) e = ord_q.pop_front();
      else if (exp_q[d[7:6]].size() > 0) e = exp_q[d[7:6]].pop_front();
      else e = ~d;
      checks++; if (d !== e) begin errors++; $display("FAIL fifo_read got=%h exp=%h", d, e); end
    end
    if (wen) fifo_q.push_back(wd);
    fifo_full = (fifo_q.size() >= DEPTH);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        grant_log.push_back(i);
        void'(src[i].pop_front());
        if (src[i].size() > 0) wait_cnt[i] = src[i][0].gap;
      end else if (wait_cnt[i] > 0) wait_cnt[i]--;
    end
    drive();
    @(negedge clk);
  endtask

  task automatic finish_test(int bound);
    int n = 0;
    rd_en = 1'b1;
    while ((any_src() || busy || fifo_q.size() > 0) && n < bound) begin cycle(); n++; end
    checks++; if (n >= bound) begin errors++; $display("FAIL drain_timeout cycles=%0d limit=%0d", n, bound); end
  endtask

  task automatic apply_reset();
    rst = 1'b1; cycle(); rst = 1'b0;
    grant_log.delete(); gv_log.delete();
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
    checks++; if (fifo_wen !== 1'b0 || fifo_wdata !== '0) begin errors++; $display("FAIL reset_wr wen=%b wdata=%h exp 0/00", fifo_wen, fifo_wdata); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_bursts();
    logic [3:0] ev[6] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100};
    grant_log.delete(); gv_log.delete();
    load(0, 8'hA0, 1'b0, 0, 1'b1); load(0, 8'hA1, 1'b1, 0, 1'b1);
    load(2, 8'hC0, 1'b0, 0, 1'b1); load(2, 8'hC1, 1'b1, 0, 1'b1);
    cycle(); #1;
    checks++; if (busy !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL t1_first_owner busy=%b owner=%0d exp 1/0", busy, owner); end
    finish_test(100);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= gv_log.size() || gv_log[k] !== ev[k]) begin
        errors++; $display("FAIL t1_grant_seq cyc=%0d got=%b exp=%b", k, (k < gv_log.size()) ? gv_log[k] : 4'bxxxx, ev[k]);
      end
    end
    checks++; if (ord_q.size() != 0) begin errors++; $display("FAIL t1_unread got=%0d exp=0", ord_q.size()); end
  endtask

  task automatic test_max_burst();
    int exp_ids[$];
    apply_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) for (int b = 0; b < MB; b++) exp_ids.push_back(i);
    for (int i = 0; i < N; i++) for (int b = 0; b < 2*MB; b++) begin
      load(i, {i[1:0], seq[i]}, 1'b0, 0, 1'b0); seq[i]++;
    end
    finish_test(300);
    checks++; if (grant_log.size() != exp_ids.size()) begin errors++; $display("FAIL t2_beats got=%0d exp=%0d", grant_log.size(), exp_ids.size()); end
    for (int k = 0; k < exp_ids.size() && k < grant_log.size(); k++) begin
      checks++; if (grant_log[k] != exp_ids[k]) begin errors++; $display("FAIL t2_order beat=%0d got=%0d exp=%0d", k, grant_log[k], exp_ids[k]); end
    end
  endtask

  task automatic test_fifo_full();
    int n = 0;
    apply_reset();
    rd_en = 1'b0;
    for (int k = 0; k < DEPTH - 2; k++) begin
      fifo_q.push_back({2'd3, seq[3]}); exp_q[3].push_back({2'd3, seq[3]}); seq[3]++;
    end
    for (int b = 0; b < MB; b++) begin load(1, {2'd1, seq[1]}, 1'b0, 0, 1'b0); seq[1]++; end
    while (!fifo_full && n < 20) begin cycle(); n++; end
    checks++; if (grant_log.size() != 2) begin errors++; $display("FAIL t3_beats_before_full got=%0d exp=2", grant_log.size()); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (grant !== '0 || fifo_wen !== 1'b0) begin errors++; $display("FAIL t3_stall grant=%b wen=%b exp 0/0", grant, fifo_wen); end
      checks++; if (busy !== 1'b1 || owner !== 2'd1) begin errors++; $display("FAIL t3_lock busy=%b owner=%0d exp 1/1", busy, owner); end
      cycle();
    end
    rd_en = 1'b1; cycle(); rd_en = 1'b0; #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t3_resume got=%b exp=0010", grant); end
    finish_test(200);
    checks++; if (grant_log.size() != MB) begin errors++; $display("FAIL t3_total got=%0d exp=%0d", grant_log.size(), MB); end
  endtask

  task automatic test_owner_stall();
    int n = 0;
    apply_reset();
    load(3, {2'd3, seq[3]}, 1'b0, 0, 1'b0); seq[3]++;
    load(3, {2'd3, seq[3]}, 1'b1, 5, 1'b0); seq[3]++;
    while (grant_log.size() < 1 && n < 10) begin cycle(); n++; end
    load(0, {2'd0, seq[0]}, 1'b1, 0, 1'b0); seq[0]++;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (owner !== 2'd3 || busy !== 1'b1 || grant !== '0) begin
        errors++; $display("FAIL t4_hold owner=%0d busy=%b grant=%b exp 3/1/0000", owner, busy, grant);
      end
      cycle();
    end
    finish_test(100);
    checks++; if (grant_log.size() != 3 || grant_log[0] != 3 || grant_log[1] != 3 || grant_log[2] != 0) begin
      errors++; $display("FAIL t4_order beats=%0d exp 3,3,0", grant_log.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    apply_reset();
    for (int b = 0; b < MB; b++) begin load(2, {2'd2, seq[2]}, 1'b0, 0, 1'b0); seq[2]++; end
    while (grant_log.size() < 2 && n < 10) begin cycle(); n++; end
    rst = 1'b1; #1;
    checks++; if (grant !== '0 || fifo_wen !== 1'b0) begin errors++; $display("FAIL t5_rst_cycle grant=%b wen=%b exp 0/0", grant, fifo_wen); end
    cycle(); #1;
    checks++; if (busy !== 1'b0 || grant !== '0) begin errors++; $display("FAIL t5_after_rst busy=%b grant=%b exp 0/0", busy, grant); end
    rst = 1'b0;
    while (src[2].size() > 0) begin void'(src[2].pop_back()); void'(exp_q[2].pop_back()); end
    grant_log.delete();
    load(2, {2'd2, seq[2]}, 1'b0, 0, 1'b0); seq[2]++;
    load(2, {2'd2, seq[2]}, 1'b1, 0, 1'b0); seq[2]++;
    cycle(); #1;
    checks++; if (busy !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL t5_fresh busy=%b owner=%0d exp 1/2", busy, owner); end
    finish_test(100);
    checks++; if (grant_log.size() != 2) begin errors++; $display("FAIL t5_beats got=%0d exp=2", grant_log.size()); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          load(i, {i[1:0], seq[i]}, ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0);
          seq[i]++;
        end
      end
      rd_en = ($urandom_range(0, 1) == 1);
      cycle();
    end
    for (int i = 0; i < N; i++) begin load(i, {i[1:0], seq[i]}, 1'b1, 0, 1'b0); seq[i]++; end
    finish_test(2000);
    for (int i = 0; i < N; i++) begin
      checks++; if (exp_q[i].size() != 0) begin errors++; $display("FAIL t6_lost req=%0d left=%0d exp=0", i, exp_q[i].size()); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin wait_cnt[i] = 0; seq[i] = '0; end
    test_reset();
    test_two_bursts();
    test_max_burst();
    test_fifo_full();
    test_owner_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
